// File: rtl/csr_access_if.sv
// Request, response and CSR register-file signals of the CSR access unit.
// The slave modport is the unit itself; master is the surrounding pipeline.
interface csr_access_if;
    // request from decode
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  funct3;
    logic [11:0] csr_addr_in;
    logic [63:0] rs1_data;
    logic [4:0]  rs1_idx;
    logic [4:0]  rd;
    logic [63:0] pc;
    logic [1:0]  priv_lvl;

    // CSR register file
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [63:0] csr_wdata;
    logic [63:0] csr_rdata;
    logic        csr_illegal;

    // response to writeback / trap logic
    logic        rsp_valid;
    logic        rsp_ready;
    logic [4:0]  rsp_rd;
    logic        rsp_rd_we;
    logic [63:0] rsp_data;
    logic        rsp_exc;
    logic [63:0] rsp_cause;
    logic [63:0] rsp_tval;
    logic [63:0] rsp_epc;

    modport slave (
        input  req_valid, funct3, csr_addr_in, rs1_data, rs1_idx, rd, pc, priv_lvl,
        output req_ready,
        output csr_we, csr_addr, csr_wdata,
        input  csr_rdata, csr_illegal,
        output rsp_valid, rsp_rd, rsp_rd_we, rsp_data, rsp_exc, rsp_cause, rsp_tval, rsp_epc,
        input  rsp_ready
    );

    modport master (
        output req_valid, funct3, csr_addr_in, rs1_data, rs1_idx, rd, pc, priv_lvl,
        input  req_ready,
        input  csr_we, csr_addr, csr_wdata,
        output csr_rdata, csr_illegal,
        input  rsp_valid, rsp_rd, rsp_rd_we, rsp_data, rsp_exc, rsp_cause, rsp_tval, rsp_epc,
        output rsp_ready
    );
endinterface

// File: rtl/csr_access_unit.sv
// Sequences one Zicsr instruction: read the CSR, optionally write it, then respond.
// Define CSR_ACCESS_RO_CHECK_EN to trap writes to read-only CSRs (addr[11:10]==2'b11).
module csr_access_unit (
    input  logic         clk,
    input  logic         reset,
    csr_access_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [2:0]  funct3_reg;
    logic [11:0] addr_reg;
    logic [63:0] rs1_data_reg;
    logic [4:0]  rs1_idx_reg;
    logic [4:0]  rd_reg;
    logic [63:0] pc_reg;
    logic [1:0]  priv_reg;
    logic [63:0] old_val_reg;
    logic [63:0] new_val_reg;
    logic        exc_reg;
    logic        rd_we_reg;

    logic        accept;
    logic        is_imm;
    logic [1:0]  op_kind;
    logic        op_legal;
    logic [63:0] operand;
    logic [63:0] set_val;
    logic [63:0] clr_val;
    logic [63:0] new_val;
    logic        write_req;
    logic        priv_fault;
    logic        ro_fault;
    logic        exc;

    assign accept   = (state_reg == IDLE) && bus.req_valid;
    assign is_imm   = funct3_reg[2];
    assign op_kind  = funct3_reg[1:0];
    assign op_legal = (op_kind != 2'b00);
    assign operand  = is_imm ? {59'b0, rs1_idx_reg} : rs1_data_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_bit
            assign set_val[gi] = bus.csr_rdata[gi] | operand[gi];
            assign clr_val[gi] = bus.csr_rdata[gi] & ~operand[gi];
        end
    endgenerate

    always_comb begin
        new_val = operand;
        case (op_kind)
            2'b10:   new_val = set_val;
            2'b11:   new_val = clr_val;
            default: new_val = operand;
        endcase
    end

    // Set/clear with x0 (or zimm 0) is a pure read and must not touch the CSR.
    assign write_req  = op_legal && ((op_kind == 2'b01) || (rs1_idx_reg != 5'd0));
    assign priv_fault = (addr_reg[9:8] > priv_reg);

`ifdef CSR_ACCESS_RO_CHECK_EN
    assign ro_fault = write_req && (addr_reg[11:10] == 2'b11);
`else
    assign ro_fault = 1'b0;
`endif

    assign exc = !op_legal || bus.csr_illegal || priv_fault || ro_fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.req_valid) state_next = READ;
            READ:    state_next = (write_req && !exc) ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            funct3_reg   <= 3'd0;
            addr_reg     <= 12'd0;
            rs1_data_reg <= 64'd0;
            rs1_idx_reg  <= 5'd0;
            rd_reg       <= 5'd0;
            pc_reg       <= 64'd0;
            priv_reg     <= 2'd0;
            old_val_reg  <= 64'd0;
            new_val_reg  <= 64'd0;
            exc_reg      <= 1'b0;
            rd_we_reg    <= 1'b0;
        end else begin
            if (accept) begin
                funct3_reg   <= bus.funct3;
                addr_reg     <= bus.csr_addr_in;
                rs1_data_reg <= bus.rs1_data;
                rs1_idx_reg  <= bus.rs1_idx;
                rd_reg       <= bus.rd;
                pc_reg       <= bus.pc;
                priv_reg     <= bus.priv_lvl;
            end
            // Response fields are frozen after READ so they stay stable while RESP stalls.
            if (state_reg == READ) begin
                old_val_reg <= bus.csr_rdata;
                new_val_reg <= new_val;
                exc_reg     <= exc;
                rd_we_reg   <= (rd_reg != 5'd0) && !exc;
            end
        end
    end

    assign bus.req_ready = (state_reg == IDLE);
    assign bus.csr_we    = (state_reg == WRITE);
    assign bus.csr_addr  = addr_reg;
    assign bus.csr_wdata = new_val_reg;

    assign bus.rsp_valid = (state_reg == RESP);
    assign bus.rsp_rd    = rd_reg;
    assign bus.rsp_rd_we = rd_we_reg;
    assign bus.rsp_data  = old_val_reg;
    assign bus.rsp_exc   = exc_reg;
    assign bus.rsp_cause = exc_reg ? 64'd2 : 64'd0;
    assign bus.rsp_tval  = exc_reg ? {52'b0, addr_reg} : 64'd0;
    assign bus.rsp_epc   = pc_reg;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed and random CSR instructions against a rule-level model of CSR access.
module tb_csr_access_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    csr_access_if bus();

    csr_access_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef CSR_ACCESS_RO_CHECK_EN
    localparam bit RO_CHECK = 1'b1;
`else
    localparam bit RO_CHECK = 1'b0;
`endif

    // CSR register file model: combinational read, contents owned by the stimulus process.
    logic [63:0] mem [0:4095];
    logic        file_illegal;
    assign bus.csr_rdata   = mem[bus.csr_addr];
    assign bus.csr_illegal = file_illegal;

    int          we_count = 0;
    logic [11:0] w_addr;
    logic [63:0] w_data;
    always @(posedge clk) begin
        if (bus.csr_we === 1'b1) begin
            we_count <= we_count + 1;
            w_addr   <= bus.csr_addr;
            w_data   <= bus.csr_wdata;
        end
    end

    int tests  = 0;
    int failed = 0;
    int txn    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL txn%0d %s: observed %0h expected %0h", txn, tag, obs, exp);
        end
    endtask

    task automatic run_req(input logic [2:0] f3, input logic [11:0] a, input logic [63:0] d,
                           input logic [4:0] idx, input logic [4:0] rdv, input logic [63:0] pcv,
                           input logic [1:0] pv, input bit ill, input int hold);
        logic [63:0] old, op, nv;
        bit legal, writes, exc, dw;
        int lat, base;
        // Expected behaviour from the instruction rules
        legal = (f3[1:0] != 2'b00);
        op    = f3[2] ? {59'b0, idx} : d;
        old   = mem[a];
        case (f3[1:0])
            2'b01:   nv = op;
            2'b10:   nv = old | op;
            2'b11:   nv = old & ~op;
            default: nv = old;
        endcase
        writes = legal && ((f3[1:0] == 2'b01) || (idx != 5'd0));
        exc    = !legal || ill || (a[9:8] > pv) || (RO_CHECK && writes && (a[11:10] == 2'b11));
        dw     = writes && !exc;

        txn++;
        @(negedge clk);
        file_illegal    = ill;
        bus.rsp_ready   = (hold == 0);
        bus.funct3      = f3;
        bus.csr_addr_in = a;
        bus.rs1_data    = d;
        bus.rs1_idx     = idx;
        bus.rd          = rdv;
        bus.pc          = pcv;
        bus.priv_lvl    = pv;
        bus.req_valid   = 1'b1;
        check("req_ready_idle", bus.req_ready, 1'b1);
        base = we_count;
        @(posedge clk);
        // The accepting cycle is cycle 0; lat is the cycle in which rsp_valid is seen.
        lat = 0;
        do begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            lat++;
        end while (bus.rsp_valid !== 1'b1 && lat < 8);
        check("latency", 64'(lat), dw ? 64'd3 : 64'd2);
        check("rsp_data", bus.rsp_data, old);
        check("rsp_rd", 64'(bus.rsp_rd), 64'(rdv));
        check("rsp_rd_we", 64'(bus.rsp_rd_we), 64'((rdv != 5'd0) && !exc));
        check("rsp_exc", 64'(bus.rsp_exc), 64'(exc));
        check("rsp_epc", bus.rsp_epc, pcv);
        if (exc) begin
            check("rsp_cause", bus.rsp_cause, 64'd2);
            check("rsp_tval", bus.rsp_tval, {52'b0, a});
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 64'(bus.rsp_valid), 64'd1);
            check("hold_req_ready", 64'(bus.req_ready), 64'd0);
            check("hold_data", bus.rsp_data, old);
            check("hold_exc", 64'(bus.rsp_exc), 64'(exc));
            check("hold_rd_we", 64'(bus.rsp_rd_we), 64'((rdv != 5'd0) && !exc));
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rsp_done", 64'(bus.rsp_valid), 64'd0);
        check("req_ready_after", 64'(bus.req_ready), 64'd1);
        bus.rsp_ready = 1'b0;
        check("we_cycles", 64'(we_count - base), dw ? 64'd1 : 64'd0);
        if (dw) begin
            check("wr_addr", 64'(w_addr), 64'(a));
            check("wr_data", w_data, nv);
            mem[a] = nv;
        end
        $display("[TB] txn %0d f3=%0d addr=%03h priv=%0d old=%0h exc=%0b write=%0b lat=%0d",
                 txn, f3, a, pv, old, exc, dw, lat);
    endtask

    initial begin
        logic [11:0] ra;
        logic [1:0]  rp;
        logic [4:0]  ridx, rrd;
        int          base;

        for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom};
        file_illegal    = 1'b0;
        bus.req_valid   = 1'b0;
        bus.rsp_ready   = 1'b0;
        bus.funct3      = 3'd0;
        bus.csr_addr_in = 12'd0;
        bus.rs1_data    = 64'd0;
        bus.rs1_idx     = 5'd0;
        bus.rd          = 5'd0;
        bus.pc          = 64'd0;
        bus.priv_lvl    = 2'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_csr_we", 64'(bus.csr_we), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_exc", 64'(bus.rsp_exc), 64'd0);
        check("rst_rsp_rd_we", 64'(bus.rsp_rd_we), 64'd0);
        check("rst_csr_addr", 64'(bus.csr_addr), 64'd0);
        check("rst_csr_wdata", bus.csr_wdata, 64'd0);
        check("rst_rsp_data", bus.rsp_data, 64'd0);
        check("rst_rsp_cause", bus.rsp_cause, 64'd0);
        check("rst_rsp_tval", bus.rsp_tval, 64'd0);
        check("rst_rsp_epc", bus.rsp_epc, 64'd0);
        reset = 1'b0;

        // CSRRW sstatus-range CSR from S-mode
        mem[12'h140] = 64'h11;
        run_req(3'b001, 12'h140, 64'hAA, 5'd7, 5'd5, 64'h8000_0000, 2'd1, 1'b0, 0);
        check("rw_wdata_const", w_data, 64'hAA);
        // CSRRS with x0: read only
        mem[12'h100] = 64'h1234_5678;
        run_req(3'b010, 12'h100, 64'hFFFF, 5'd0, 5'd3, 64'h8000_0004, 2'd1, 1'b0, 0);
        // CSRRCI zimm=3 on 0xF
        mem[12'h144] = 64'hF;
        run_req(3'b111, 12'h144, 64'h0, 5'd3, 5'd9, 64'h8000_0008, 2'd1, 1'b0, 0);
        check("rci_wdata_const", w_data, 64'hC);
        // S-mode CSR accessed from U-mode
        run_req(3'b001, 12'h105, 64'h77, 5'd1, 5'd4, 64'h8000_000C, 2'd0, 1'b0, 0);
        // Write to a read-only-range address from M-mode
        run_req(3'b001, 12'hC00, 64'h55, 5'd2, 5'd6, 64'h8000_0010, 2'd3, 1'b0, 0);
        // Illegal funct3 encodings and file-side illegal flag
        run_req(3'b000, 12'h300, 64'h1, 5'd1, 5'd1, 64'h8000_0014, 2'd3, 1'b0, 0);
        run_req(3'b100, 12'h300, 64'h1, 5'd1, 5'd1, 64'h8000_0018, 2'd3, 1'b0, 0);
        run_req(3'b011, 12'h340, 64'hF0, 5'd8, 5'd2, 64'h8000_001C, 2'd3, 1'b1, 0);
        // Consumer stalls the response for four cycles
        run_req(3'b110, 12'h341, 64'h0, 5'd5, 5'd12, 64'h8000_0020, 2'd3, 1'b0, 4);

        // Reset while the write cycle is on the CSR bus aborts the request
        txn++;
        @(negedge clk);
        bus.funct3      = 3'b001;
        bus.csr_addr_in = 12'h142;
        bus.rs1_data    = 64'h5A5A;
        bus.rs1_idx     = 5'd1;
        bus.rd          = 5'd1;
        bus.pc          = 64'h8000_0024;
        bus.priv_lvl    = 2'd3;
        bus.rsp_ready   = 1'b1;
        bus.req_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_in_write", 64'(bus.csr_we), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        base = we_count;
        check("abort_csr_we", 64'(bus.csr_we), 64'd0);
        check("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("abort_no_rsp", 64'(bus.rsp_valid), 64'd0);
        end
        check("abort_no_we", 64'(we_count - base), 64'd0);
        mem[12'h142] = 64'h5A5A;
        bus.rsp_ready = 1'b0;
        $display("[TB] txn %0d reset during WRITE, request aborted", txn);

        // Random instructions
        for (int n = 0; n < 40; n++) begin
            ra   = 12'($urandom);
            case ($urandom_range(0, 2))
                0:       rp = 2'd0;
                1:       rp = 2'd1;
                default: rp = 2'd3;
            endcase
            ridx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rrd  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            run_req(3'($urandom), ra, {$urandom, $urandom}, ridx, rrd, {$urandom, $urandom},
                    rp, ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
